// File: rtl/ntt_butterfly_post_if.sv
// Butterfly-completion bus: reducer-side inputs in, X/Y results out.
// Shared by the butterfly post stage and whatever drives it.
interface ntt_butterfly_post_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 3
);
    logic                  clr;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] wb_red;
    logic [DATA_WIDTH-1:0] modulus;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] x_out;
    logic [DATA_WIDTH-1:0] y_out;
    logic [CNT_W-1:0]      bf_cnt;
    logic                  stage_done;

    modport master (
        output clr, in_valid, a_in, wb_red, modulus,
        input  out_valid, x_out, y_out, bf_cnt, stage_done
    );

    modport slave (
        input  clr, in_valid, a_in, wb_red, modulus,
        output out_valid, x_out, y_out, bf_cnt, stage_done
    );
endinterface

// File: rtl/ntt_butterfly_post.sv
// Radix-2 CT butterfly completion: aligns A with the reduced W*B product
// and emits (A+WB) mod q / (A-WB) mod q, counting butterflies per stage.
module ntt_butterfly_post #(
    parameter int DATA_WIDTH = 8,
    parameter int REDUCE_LAT = 2,
    parameter int N_POINTS   = 16
) (
    input logic                clk,
    input logic                rst_n,
    ntt_butterfly_post_if.slave bus
);
    localparam int HALF  = N_POINTS / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [REDUCE_LAT-1:0][DATA_WIDTH-1:0] a_dly_q, a_dly_d;
    logic [REDUCE_LAT-1:0]                 v_dly_q, v_dly_d;
    logic                                  out_valid_q, out_valid_d;
    logic                                  stage_done_q, stage_done_d;
    logic [DATA_WIDTH-1:0]                 x_q, x_d;
    logic [DATA_WIDTH-1:0]                 y_q, y_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] a_d;
    logic                  v_d;
    logic [DATA_WIDTH:0]   q_ext;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] x_res;
    logic [DATA_WIDTH-1:0] y_res;

    assign a_d = a_dly_q[REDUCE_LAT-1];
    assign v_d = v_dly_q[REDUCE_LAT-1];

    always_comb begin
        a_dly_d    = a_dly_q;
        v_dly_d    = v_dly_q;
        a_dly_d[0] = bus.a_in;
        v_dly_d[0] = bus.in_valid;
        for (int k = 1; k < REDUCE_LAT; k++) begin
            a_dly_d[k] = a_dly_q[k-1];
            v_dly_d[k] = v_dly_q[k-1];
        end
        // clr drops everything in flight, including this cycle's beat
        if (bus.clr) begin
            v_dly_d = '0;
        end
    end

    always_comb begin
        q_ext = {1'b0, bus.modulus};
        sum   = {1'b0, a_d} + {1'b0, bus.wb_red};
        diff  = {1'b0, a_d} - {1'b0, bus.wb_red};
        x_res = (sum >= q_ext) ? DATA_WIDTH'(sum - q_ext)
                               : DATA_WIDTH'(sum);
        y_res = diff[DATA_WIDTH] ? DATA_WIDTH'(diff + q_ext)
                                 : DATA_WIDTH'(diff);
    end

    always_comb begin
        out_valid_d  = 1'b0;
        stage_done_d = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        cnt_d        = cnt_q;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (v_d) begin
            out_valid_d = 1'b1;
            x_d         = x_res;
            y_d         = y_res;
            if (cnt_q == CNT_LAST) begin
                cnt_d        = '0;
                stage_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dly_q      <= '0;
            v_dly_q      <= '0;
            out_valid_q  <= 1'b0;
            stage_done_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
        end else begin
            a_dly_q      <= a_dly_d;
            v_dly_q      <= v_dly_d;
            out_valid_q  <= out_valid_d;
            stage_done_q <= stage_done_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.stage_done = stage_done_q;
    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.bf_cnt     = cnt_q;
endmodule

// File: tb/tb_ntt_butterfly_post.sv
// Directed + randomized bench for ntt_butterfly_post against a
// modular-arithmetic reference with an output-count model.
module tb_ntt_butterfly_post;
    localparam int DW   = 8;
    localparam int LAT  = 2;
    localparam int NP   = 16;
    localparam int HALF = NP / 2;
    localparam int CW   = 3;

    logic clk;
    logic rst_n;

    ntt_butterfly_post_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

    ntt_butterfly_post #(
        .DATA_WIDTH(DW),
        .REDUCE_LAT(LAT),
        .N_POINTS(NP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int cyc;
    int q;
    int outs;
    int wb_at[int];
    int exp_x[int];
    int exp_y[int];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs of the cycle just entered, compared with the model
    task automatic check_cycle();
        if (exp_x.exists(cyc)) begin
            outs++;
            chk("out_valid", 32'(bus.out_valid), 1);
            chk("x_out", 32'(bus.x_out), exp_x[cyc]);
            chk("y_out", 32'(bus.y_out), exp_y[cyc]);
            chk("bf_cnt", 32'(bus.bf_cnt), outs % HALF);
            chk("stage_done", 32'(bus.stage_done),
                (outs % HALF == 0) ? 1 : 0);
            exp_x.delete(cyc);
            exp_y.delete(cyc);
        end else begin
            chk("idle_valid", 32'(bus.out_valid), 0);
            chk("idle_done", 32'(bus.stage_done), 0);
            chk("idle_cnt", 32'(bus.bf_cnt), outs % HALF);
        end
    endtask

    task automatic step(input bit v, input int a, input int wb,
                        input bit c);
        bus.in_valid = v;
        bus.a_in     = DW'(a);
        bus.clr      = c;
        bus.modulus  = DW'(q);
        if (wb_at.exists(cyc)) begin
            bus.wb_red = DW'(wb_at[cyc]);
            wb_at.delete(cyc);
        end else begin
            bus.wb_red = DW'($urandom_range(0, 255));
        end
        if (c) begin
            for (int k = 1; k <= LAT + 1; k++) begin
                exp_x.delete(cyc + k);
                exp_y.delete(cyc + k);
                wb_at.delete(cyc + k);
            end
            outs = 0;
        end else if (v) begin
            wb_at[cyc + LAT]     = wb;
            exp_x[cyc + LAT + 1] = (a + wb) % q;
            exp_y[cyc + LAT + 1] = (a + q - wb) % q;
        end
        @(posedge clk);
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic rand_beat(input bit v);
        step(v, $urandom_range(0, q - 1), $urandom_range(0, q - 1), 1'b0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        outs         = 0;
        q            = 97;
        rst_n        = 1'b0;
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        bus.wb_red   = '0;
        bus.modulus  = DW'(q);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_x", 32'(bus.x_out), 0);
        chk("rst_y", 32'(bus.y_out), 0);
        chk("rst_cnt", 32'(bus.bf_cnt), 0);
        chk("rst_done", 32'(bus.stage_done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single butterfly: 50,60 mod 97 -> 13,87
        step(1'b1, 50, 60, 1'b0);
        idle(4);
        chk("x_50_60", 32'(bus.x_out), 13);
        chk("y_50_60", 32'(bus.y_out), 87);

        // Modular corners back to back
        step(1'b1, 0, 0, 1'b0);
        step(1'b1, 96, 96, 1'b0);
        step(1'b1, 0, 96, 1'b0);
        step(1'b1, 96, 1, 1'b0);
        idle(4);

        // Fresh stage: 8 beats then 3 more, checks wrap and stage_done
        step(1'b0, 0, 0, 1'b1);
        idle(1);
        for (int i = 0; i < HALF + 3; i++) rand_beat(1'b1);
        idle(4);

        // Gapped beats
        step(1'b0, 0, 0, 1'b1);
        idle(1);
        rand_beat(1'b1);
        idle(1);
        rand_beat(1'b1);
        idle(2);
        rand_beat(1'b1);
        idle(4);

        // clr in the cycle of the second beat; third beat survives
        step(1'b0, 0, 0, 1'b1);
        idle(1);
        rand_beat(1'b1);
        step(1'b1, 7, 9, 1'b1);
        rand_beat(1'b1);
        idle(4);

        // Random moduli and random valid patterns
        for (int r = 0; r < 4; r++) begin
            idle(LAT + 2);
            q = $urandom_range(2, 255);
            for (int i = 0; i < 20; i++) rand_beat(1'($urandom_range(0, 1)));
        end
        idle(LAT + 2);

        // Async reset mid-stage once five outputs are counted
        q = 97;
        step(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 40 && outs % HALF != 5; i++) rand_beat(1'b1);
        chk("pre_rst_cnt", 32'(bus.bf_cnt), 5);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_cnt", 32'(bus.bf_cnt), 0);
        chk("arst_x", 32'(bus.x_out), 0);
        chk("arst_y", 32'(bus.y_out), 0);
        chk("arst_done", 32'(bus.stage_done), 0);
        exp_x.delete();
        exp_y.delete();
        wb_at.delete();
        outs = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        rand_beat(1'b1);
        rand_beat(1'b1);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ntt_butterfly_post.md
Name: ntt_butterfly_post

Overview:
Cooley-Tukey radix-2 butterfly completion stage. It sits directly downstream of the Barrett reduction unit and consumes its reduced twiddle product W*B mod q. It delays the matching A operand to align with the reducer's fixed latency. It then produces X = (A + WB) mod q and Y = (A - WB) mod q, and tracks butterfly count per NTT stage.

Parameters:
DATA_WIDTH, 8, coefficient/modulus width (matches reducer output width)
REDUCE_LAT, 2, cycles from product launch into reducer to reduced result valid
N_POINTS, 16, NTT size; one stage = N_POINTS/2 butterflies (power of 2, >=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of pipeline valids and counter
in_valid  input  1  high in the cycle the A*... product (W*B) is launched into the reducer
a_in  input  DATA_WIDTH  A operand, sampled with in_valid, < modulus
wb_red  input  DATA_WIDTH  reduced product from reducer; valid exactly REDUCE_LAT cycles after matching in_valid
modulus  input  DATA_WIDTH  q; held stable for the duration of a stage
out_valid  output  1  X/Y valid
x_out  output  DATA_WIDTH  (A + WB) mod q
y_out  output  DATA_WIDTH  (A - WB) mod q
bf_cnt  output  $clog2(N_POINTS/2) (min 1)  index of next butterfly output within stage
stage_done  output  1  one-cycle pulse with the last out_valid of a stage

Behaviour:
- Reset (rst_n=0, async): out_valid=0, x_out=0, y_out=0, bf_cnt=0, stage_done=0, all delay-line registers and valid bits=0. Deassertion is synchronous to clk by the instantiating parent.
- Delay line: REDUCE_LAT-deep shift registers for a_in and in_valid. The shift occurs every cycle; no stall/backpressure. Stage k holds the value presented k cycles earlier.
- Alignment: at the tail of the delay line (a_d, v_d), wb_red corresponds to the same butterfly. wb_red is ignored when v_d=0.
- Arithmetic (combinational on a_d, wb_red, modulus):
  - sum = a_d + wb_red in DATA_WIDTH+1 bits; X = (sum >= q) ? sum - q : sum.
  - diff = a_d - wb_red in DATA_WIDTH+1 bits; Y = diff[MSB] ? diff + q : diff, truncated to DATA_WIDTH.
  - Both operands are required to be < q; results for out-of-range operands are unspecified but must not hang state.
- Output register: when v_d=1, x_out/y_out load X/Y and out_valid=1. When v_d=0, out_valid=0 and x_out/y_out hold their previous values.
- Latency: in_valid at cycle t gives out_valid at t+REDUCE_LAT+1 (default t+3). Throughput is 1 butterfly/cycle; back-to-back in_valid is fully supported.
- Counter: bf_cnt increments on each cycle where out_valid is asserted (registered alongside outputs). stage_done=1 in the same cycle as the out_valid whose pre-increment count equals N_POINTS/2-1. bf_cnt then wraps to 0; there is no saturation.
- clr (sync): next cycle all delay valid bits, out_valid, stage_done=0 and bf_cnt=0. In-flight butterflies are discarded, and data registers may keep stale values. clr has priority over in_valid sampled in the same cycle; that beat is dropped.
- Async reset mid-stage discards everything immediately; the first beat after release counts as bf_cnt=0.
- Gaps in in_valid do not reset bf_cnt; the stage spans until N_POINTS/2 outputs have occurred.

Test Plan:
- q=97, in_valid at cycle 0 with a_in=50, wb_red=60 driven at cycle 2 -> at cycle 3 out_valid=1, x_out=13, y_out=87; out_valid=0 at cycles 1-2 and 4.
- q=97, corners (a,wb) = (0,0), (96,96), (0,96), (96,1) on consecutive cycles -> (x,y) = (0,0), (95,0), (96,1), (0,95) on 4 consecutive out_valid cycles.
- N_POINTS=16, 8 back-to-back valid beats followed by 3 more -> stage_done only on 8th output with bf_cnt wrapping to 0; outputs 9-11 show bf_cnt 1,2,3 and stage_done=0.
- Valid gaps: beats at cycles 0, 2, 5 -> out_valid at exactly 3, 5, 8 with matching data; bf_cnt progresses 0->1->2->3 only on those cycles.
- clr asserted at cycle 1 with beats issued at cycles 0 and 1 -> no out_valid at cycles 3 or 4, bf_cnt=0; a beat at cycle 2 appears at cycle 5 as bf_cnt index 0.
- rst_n low for 1 cycle asynchronously mid-stream (bf_cnt=5) -> outputs, valids and bf_cnt clear immediately without clk edge; post-release stream restarts at bf_cnt=0.
